// File: rtl/alu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_buffer
// Description : Elastic ALU-to-writeback result FIFO with 4-phase req/ack on
//               both sides and a pending-write query for hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_req,
    output logic                     in_ack,
    input  logic [DATA_W-1:0]        in_result,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic                     in_we,
    input  logic                     in_zero,
    input  logic                     in_neg,
    output logic                     out_req,
    input  logic                     out_ack,
    output logic [DATA_W-1:0]        out_result,
    output logic [ADDR_W-1:0]        out_rd,
    output logic                     out_we,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    input  logic [ADDR_W-1:0]        query_addr,
    output logic                     query_busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_ENT_W = DATA_W + ADDR_W + 3;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    localparam logic [0:0] c_IN_IDLE  = 1'b0;
    localparam logic [0:0] c_IN_ACK   = 1'b1;

    localparam logic [1:0] c_OUT_IDLE = 2'd0;
    localparam logic [1:0] c_OUT_REQ  = 2'd1;
    localparam logic [1:0] c_OUT_WAIT = 2'd2;

    // Entry layout: {result, rd, we, zero, neg}
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               r_full;
    logic               r_empty;

    logic [0:0]         r_in_state;
    logic [0:0]         w_in_state_nxt;
    logic [1:0]         r_out_state;
    logic [1:0]         w_out_state_nxt;

    logic               w_push;
    logic               w_pop;
    logic               w_load;

    logic [c_ENT_W-1:0] r_out_ent;
    logic [c_ENT_W-1:0] w_in_ent;
    logic [c_PTR_W-1:0] w_off;
    logic               w_busy;

    assign w_in_ent = {in_result, in_rd, in_we, in_zero, in_neg};

    always_comb begin
        w_in_state_nxt = r_in_state;
        w_push         = 1'b0;
        case (r_in_state)
            c_IN_IDLE: begin
                if (in_req && !r_full) begin
                    w_push         = 1'b1;
                    w_in_state_nxt = c_IN_ACK;
                end
            end
            c_IN_ACK: begin
                if (!in_req) begin
                    w_in_state_nxt = c_IN_IDLE;
                end
            end
            default: w_in_state_nxt = c_IN_IDLE;
        endcase
    end

    always_comb begin
        w_out_state_nxt = r_out_state;
        w_load          = 1'b0;
        w_pop           = 1'b0;
        case (r_out_state)
            c_OUT_IDLE: begin
                if (!r_empty && !out_ack) begin
                    w_load          = 1'b1;
                    w_out_state_nxt = c_OUT_REQ;
                end
            end
            c_OUT_REQ: begin
                if (out_ack) begin
                    w_pop           = 1'b1;
                    w_out_state_nxt = c_OUT_WAIT;
                end
            end
            c_OUT_WAIT: begin
                if (!out_ack) begin
                    w_out_state_nxt = c_OUT_IDLE;
                end
            end
            default: w_out_state_nxt = c_OUT_IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
            2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state  <= c_IN_IDLE;
            r_out_state <= c_OUT_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_out_ent   <= '0;
        end else begin
            r_in_state  <= w_in_state_nxt;
            r_out_state <= w_out_state_nxt;
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == c_FULL_CNT);
            r_empty     <= (w_count_nxt == '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_load) begin
                r_out_ent <= r_mem[r_rd_ptr];
            end
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        w_busy = 1'b0;
        w_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = c_PTR_W'(i) - r_rd_ptr;
            if (({1'b0, w_off} < r_count) && r_mem[i][2] &&
                (r_mem[i][ADDR_W+2:3] == query_addr)) begin
                w_busy = 1'b1;
            end
        end
    end

    assign in_ack     = (r_in_state == c_IN_ACK);
    assign out_req    = (r_out_state == c_OUT_REQ);
    assign out_result = r_out_ent[c_ENT_W-1 -: DATA_W];
    assign out_rd     = r_out_ent[ADDR_W+2:3];
    assign out_we     = r_out_ent[2];
    assign out_zero   = r_out_ent[1];
    assign out_neg    = r_out_ent[0];
    assign count      = r_count;
    assign full       = r_full;
    assign empty      = r_empty;
    assign query_busy = w_busy;

endmodule
`default_nettype wire

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
Elastic result buffer between the ALU stage and the writeback stage. It captures ALU results with a 4-phase req/ack handshake on the upstream side and queues them in a small FIFO. Each queued result is presented to writeback with its own 4-phase req/ack handshake. It also exposes a pending-write query so ID-side hazard logic can tell whether a register still has an in-flight write.

Parameters:
DATA_W, 16, width of the ALU result
ADDR_W, 4, width of the destination register address
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  stage clock
rst  input  1  synchronous reset, active-high
in_req  input  1  upstream request from ALU side (4-phase)
in_ack  output  1  upstream acknowledge
in_result  input  DATA_W  ALU result
in_rd  input  ADDR_W  destination register
in_we  input  1  write enable for this result
in_zero  input  1  ALU zero flag
in_neg  input  1  ALU negative flag
out_req  output  1  request to writeback (4-phase)
out_ack  input  1  writeback acknowledge
out_result  output  DATA_W  head-entry result
out_rd  output  ADDR_W  head-entry destination
out_we  output  1  head-entry write enable
out_zero  output  1  head-entry zero flag
out_neg  output  1  head-entry negative flag
count  output  $clog2(DEPTH)+1  number of valid entries
full  output  1  count == DEPTH
empty  output  1  count == 0
query_addr  input  ADDR_W  register address to check
query_busy  output  1  a valid entry has we=1 and rd==query_addr

Behaviour:
Reset (clk edge with rst=1):
- in_ack, out_req, and all out_* data are 0.
- count=0, empty=1, full=0.
- Read and write pointers are 0; both FSMs return to IDLE.
- Reset mid-handshake discards every queued entry, including one currently being presented.

Input FSM:
- IN_IDLE: on an edge with in_req=1 and full=0, write {result, rd, we, zero, neg} at wr_ptr, increment wr_ptr (mod DEPTH), set in_ack<=1, go to IN_ACK.
- IN_IDLE with in_req=1 and full=1: no capture; in_ack stays 0; retry every cycle until a slot frees.
- IN_ACK: hold in_ack=1 until an edge sees in_req=0, then in_ack<=0 and go to IN_IDLE.
- Upstream data needs to be stable only while in_req=1 and in_ack=0.

Output FSM:
- OUT_IDLE: on an edge with empty=0 and out_ack=0, load the out_* registers from the entry at rd_ptr, set out_req<=1, go to OUT_REQ. If out_ack=1 in OUT_IDLE, wait.
- OUT_REQ: out_* are held stable. On an edge with out_ack=1: out_req<=0, pop (rd_ptr+1 mod DEPTH), go to OUT_WAIT.
- OUT_WAIT: on an edge with out_ack=0, go to OUT_IDLE.

Ordering and counting:
- Strict FIFO order.
- A push and a pop on the same edge leave count unchanged.
- Pointer wrap is modulo DEPTH; full and empty are derived from count, never from pointer equality alone.

Latency:
- A write at edge k is visible to the output FSM at edge k+1.
- With the buffer empty and out_ack=0, out_req rises after edge k+1, i.e. 2 cycles after capture.
- in_ack rises 1 cycle after capture.

Throughput:
- At most one push per input 4-phase cycle (minimum 2 clocks).
- At most one pop per output 4-phase cycle (minimum 3 clocks).

query_busy:
- Combinational OR over all valid entries (rd_ptr..rd_ptr+count-1) of (we && rd==query_addr).
- The presented head entry counts until its pop edge.
- No special case for register 0.

Flags:
- count, full, and empty are registered and updated on the same edge as a push or pop.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_req=1 -> in_ack=0, out_req=0, count=0, empty=1, full=0, out_result=0.
2. Single transfer: in_result=0x1234, in_rd=5, in_we=1, in_neg=0, in_req=1 -> in_ack=1 one cycle after capture; out_req=1 two cycles after capture with out_result=0x1234, out_rd=5, out_we=1. Then pulse out_ack -> out_req falls, count=0, empty=1.
3. Fill and backpressure: hold out_ack=0 and push 0x0001..0x0004 -> full=1, count=4. A 5th push (0x0005) gets no in_ack. Complete one output handshake -> 0x0005 is acked on the next eligible edge. The drain order is 0x0001, 0x0002, 0x0003, 0x0004, 0x0005.
4. Simultaneous push/pop: with count=2, align a capture edge with the out_ack=1 edge in OUT_REQ -> count stays 2 and the next presented entry is the correct successor.
5. Hazard query: push (rd=7, we=1) then (rd=3, we=0) -> query_addr=7 gives busy=1, query_addr=3 gives busy=0. After the rd=7 entry pops, query_addr=7 gives busy=0.
6. Reset mid-operation: with out_req=1 and count=3, assert rst for 1 cycle -> next cycle out_req=0, in_ack=0, count=0, empty=1. A new push afterwards is delivered correctly (pointers restarted).
